// File: rtl/wbuf_pkg.sv
// Shared constants and types for the multi-bank weight buffer and its
// MAC-array controller.
package wbuf_pkg;

    localparam int N_BANK_DEF = 12;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 256;

    // Bank-index width; a single bank still needs one bit to carry an index.
    function automatic int bank_w(input int n_bank);
        return (n_bank > 1) ? $clog2(n_bank) : 1;
    endfunction

    localparam int BANK_W_DEF = bank_w(N_BANK_DEF);

    typedef struct packed {
        logic [BANK_W_DEF-1:0] bank;
        logic [ADDR_W_DEF-1:0] addr;
    } rd_req_t;

endpackage

// File: rtl/wbuf_bank.sv
// One single-port synchronous RAM bank with a 1-cycle read. The array is
// reachable hierarchically (u_bank[i].u_ram.mem) for simulation preload.
module wbuf_bank
    import wbuf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] dout_q;

    // NOTE: the array and its output register have no reset so the block maps
    // onto RAM macros; contents survive a reset by design.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout_q <= mem[addr];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/multi_bank_wbuf_rw.sv
// Multi-bank weight buffer: N_PORT read ports with per-bank conflict arbitration
// and same-address broadcast, one preload write port, sticky OOB error, stall counter.
module multi_bank_wbuf_rw
    import wbuf_pkg::*;
#(
    parameter int N_BANK = N_BANK_DEF,
    parameter int N_PORT = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BANK_W = bank_w(N_BANK)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORT-1:0]              rd_req_valid,
    output logic [N_PORT-1:0]              rd_req_ready,
    input  logic [N_PORT-1:0][BANK_W-1:0]  rd_bank,
    input  logic [N_PORT-1:0][ADDR_W-1:0]  rd_addr,
    output logic [N_PORT-1:0]              rd_valid,
    output logic [N_PORT-1:0][DATA_W-1:0]  rd_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [BANK_W-1:0]              wr_bank,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic                           err_bank_oob,
    output logic [31:0]                    stall_cnt
);

    localparam int STALL_W = $clog2(N_PORT + 1);

    logic                          wr_oob;
    logic                          wr_fire;
    logic [N_PORT-1:0]             rd_oob;
    logic [N_PORT-1:0]             rd_grant;
    logic [N_PORT-1:0]             win_found;
    logic [N_PORT-1:0][ADDR_W-1:0] win_addr;

    logic [N_BANK-1:0]             bank_en;
    logic [N_BANK-1:0]             bank_we;
    logic [N_BANK-1:0][ADDR_W-1:0] bank_addr;
    logic [N_BANK-1:0][DATA_W-1:0] bank_dout;

    logic [N_PORT-1:0]             acc_q,  acc_d;
    logic [N_PORT-1:0]             oob_q,  oob_d;
    logic [N_PORT-1:0][BANK_W-1:0] bank_q, bank_d;
    logic                          err_q,  err_d;
    logic [31:0]                   stall_q, stall_d;
    logic [STALL_W-1:0]            stall_sum;
    logic [32:0]                   stall_ext;

    // Grant matrix: write owns its bank; otherwise the lowest valid port on a
    // bank sets the address and every port matching it is served too.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        wr_oob    = 32'(wr_bank) >= N_BANK;
        wr_fire   = wr_valid && !rst && !wr_oob;
        wr_ready  = !rst;
        rd_oob    = '0;
        rd_grant  = '0;
        win_found = '0;
        win_addr  = '0;
        for (int p = 0; p < N_PORT; p++) begin
            rd_oob[p] = 32'(rd_bank[p]) >= N_BANK;
            for (int q = 0; q < N_PORT; q++) begin
                if (!win_found[p] && rd_req_valid[q] && rd_bank[q] == rd_bank[p]) begin
                    win_found[p] = 1'b1;
                    win_addr[p]  = rd_addr[q];
                end
            end
            rd_grant[p] = rd_req_valid[p] && !rst &&
                          (rd_oob[p] ||
                           (!(wr_fire && wr_bank == rd_bank[p]) && rd_addr[p] == win_addr[p]));
        end
        rd_req_ready = rd_grant;
    end

    always_comb begin
        bank_en   = '0;
        bank_we   = '0;
        bank_addr = '0;
        for (int b = 0; b < N_BANK; b++) begin
            if (wr_fire && wr_bank == BANK_W'(b)) begin
                bank_en[b]   = 1'b1;
                bank_we[b]   = 1'b1;
                bank_addr[b] = wr_addr;
            end else begin
                for (int p = 0; p < N_PORT; p++) begin
                    if (!bank_en[b] && rd_grant[p] && !rd_oob[p] && rd_bank[p] == BANK_W'(b)) begin
                        bank_en[b]   = 1'b1;
                        bank_addr[b] = rd_addr[p];
                    end
                end
            end
        end
    end

    for (genvar gb = 0; gb < N_BANK; gb++) begin : u_bank
        wbuf_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_ram (
            .clk  (clk),
            .en   (bank_en[gb]),
            .we   (bank_we[gb]),
            .addr (bank_addr[gb]),
            .din  (wr_data),
            .dout (bank_dout[gb])
        );
    end

    always_comb begin
        acc_d     = rd_grant;
        oob_d     = rd_oob;
        bank_d    = rd_bank;
        err_d     = err_q | (|(rd_req_valid & rd_oob)) | (wr_valid & wr_oob);
        stall_sum = '0;
        for (int p = 0; p < N_PORT; p++) begin
            stall_sum = stall_sum + STALL_W'(rd_req_valid[p] & ~rd_grant[p]);
        end
        stall_ext = {1'b0, stall_q} + 33'(stall_sum);
        stall_d   = stall_ext[32] ? 32'hFFFF_FFFF : stall_ext[31:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            oob_q   <= '0;
            bank_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            acc_q   <= acc_d;
            oob_q   <= oob_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Out-of-range accepts still return a beat, but with zero data.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < N_PORT; p++) begin
            if (acc_q[p] && !oob_q[p]) begin
                for (int b = 0; b < N_BANK; b++) begin
                    if (bank_q[p] == BANK_W'(b)) begin
                        rd_data[p] = bank_dout[b];
                    end
                end
            end
        end
    end

    assign rd_valid     = acc_q;
    assign err_bank_oob = err_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_multi_bank_wbuf_rw.sv
// Directed bench for multi_bank_wbuf_rw: stimulus pushes expected read data per
// port, a negedge monitor pops and compares whenever rd_valid is seen.
module tb_multi_bank_wbuf_rw;

    logic                clk = 1'b0;
    logic                rst;
    logic [3:0]          rd_req_valid;
    logic [3:0]          rd_req_ready;
    logic [3:0][3:0]     rd_bank;
    logic [3:0][9:0]     rd_addr;
    logic [3:0]          rd_valid;
    logic [3:0][255:0]   rd_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [3:0]          wr_bank;
    logic [9:0]          wr_addr;
    logic [255:0]        wr_data;
    logic                err_bank_oob;
    logic [31:0]         stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [255:0] exp_q [4][$];

    multi_bank_wbuf_rw dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_bank      (rd_bank),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .err_bank_oob (err_bank_oob),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // One request cycle: drive at negedge, check ready before the edge, and
    // queue the data the accepted ports must return next cycle.
    task automatic step(input logic [3:0] v, input logic [3:0][3:0] b, input logic [3:0][9:0] a,
                        input logic w, input logic [3:0] wb, input logic [9:0] wa,
                        input logic [255:0] wd, input logic [3:0] er,
                        input logic [3:0][255:0] ed, input logic push, input string tag);
        @(negedge clk);
        rd_req_valid = v;
        rd_bank      = b;
        rd_addr      = a;
        wr_valid     = w;
        wr_bank      = wb;
        wr_addr      = wa;
        wr_data      = wd;
        #1;
        check({tag, " rd_req_ready"}, 256'(rd_req_ready), 256'(er));
        if (w) check({tag, " wr_ready"}, 256'(wr_ready), 256'(1));
        if (push) begin
            for (int p = 0; p < 4; p++) begin
                if (er[p]) exp_q[p].push_back(ed[p]);
            end
        end
    endtask

    task automatic wr(input logic [3:0] wb, input logic [9:0] wa, input logic [255:0] wd);
        step(4'b0, '0, '0, 1'b1, wb, wa, wd, 4'b0, '0, 1'b0, "preload");
    endtask

    task automatic idle();
        step(4'b0, '0, '0, 1'b0, '0, '0, '0, 4'b0, '0, 1'b0, "idle");
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++) begin
                if (rd_valid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("port%0d spurious rd_valid", p), 256'(rd_valid[p]), 256'(0));
                    end else begin
                        check($sformatf("port%0d rd_data", p), rd_data[p], exp_q[p].pop_front());
                    end
                end else begin
                    check($sformatf("port%0d idle rd_data", p), rd_data[p], 256'(0));
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        rd_req_valid = 4'hF;
        rd_bank      = '0;
        rd_addr      = '0;
        wr_valid     = 1'b1;
        wr_bank      = '0;
        wr_addr      = '0;
        wr_data      = '0;
        #1;
        check("reset rd_req_ready", 256'(rd_req_ready), 256'(0));
        check("reset wr_ready", 256'(wr_ready), 256'(0));
        check("reset rd_valid", 256'(rd_valid), 256'(0));
        check("reset stall_cnt", 256'(stall_cnt), 256'(0));
        check("reset err_bank_oob", 256'(err_bank_oob), 256'(0));
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        rd_req_valid = '0;
        wr_valid     = 1'b0;

        for (int b = 0; b < 12; b++) wr(4'(b), 10'd5, 256'(b));
        wr(4'd4, 10'd9,  256'h49);
        wr(4'd4, 10'd10, 256'h4A);
        wr(4'd2, 10'd7,  256'h27);

        // Four distinct banks, one cycle, no conflicts.
        step(4'hF, {4'd11, 4'd7, 4'd3, 4'd0}, {10'd5, 10'd5, 10'd5, 10'd5}, 1'b0, '0, '0, '0,
             4'hF, {256'd11, 256'd7, 256'd3, 256'd0}, 1'b1, "distinct");
        idle();
        check("distinct stall_cnt", 256'(stall_cnt), 256'(0));

        // Same bank, different addresses: port 2 waits a cycle.
        step(4'b0101, {4'd0, 4'd4, 4'd0, 4'd4}, {10'd0, 10'd10, 10'd0, 10'd9}, 1'b0, '0, '0, '0,
             4'b0001, {256'd0, 256'd0, 256'd0, 256'h49}, 1'b1, "conflict");
        step(4'b0100, {4'd0, 4'd4, 4'd0, 4'd0}, {10'd0, 10'd10, 10'd0, 10'd0}, 1'b0, '0, '0, '0,
             4'b0100, {256'd0, 256'h4A, 256'd0, 256'd0}, 1'b1, "conflict retry");
        check("conflict stall_cnt", 256'(stall_cnt), 256'(1));

        // All ports on one word: broadcast.
        step(4'hF, {4'd2, 4'd2, 4'd2, 4'd2}, {10'd7, 10'd7, 10'd7, 10'd7}, 1'b0, '0, '0, '0,
             4'hF, {256'h27, 256'h27, 256'h27, 256'h27}, 1'b1, "broadcast");

        // Lowest port sets the address; port 2 shares it, port 1 does not.
        step(4'b0111, {4'd0, 4'd4, 4'd4, 4'd4}, {10'd0, 10'd9, 10'd10, 10'd9}, 1'b0, '0, '0, '0,
             4'b0101, {256'd0, 256'h49, 256'd0, 256'h49}, 1'b1, "mixed");
        step(4'b0010, {4'd0, 4'd0, 4'd4, 4'd0}, {10'd0, 10'd0, 10'd10, 10'd0}, 1'b0, '0, '0, '0,
             4'b0010, {256'd0, 256'd0, 256'h4A, 256'd0}, 1'b1, "mixed retry");

        // Write beats a read on the same bank; the retried read sees new data.
        step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd1}, {10'd0, 10'd0, 10'd0, 10'd3}, 1'b1, 4'd1, 10'd3, 256'hA5,
             4'b0000, '0, 1'b1, "wr vs rd");
        step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd1}, {10'd0, 10'd0, 10'd0, 10'd3}, 1'b0, '0, '0, '0,
             4'b0001, {256'd0, 256'd0, 256'd0, 256'hA5}, 1'b1, "wr vs rd retry");
        check("wr vs rd stall_cnt", 256'(stall_cnt), 256'(3));
        check("pre-oob err_bank_oob", 256'(err_bank_oob), 256'(0));

        // Out-of-range bank is accepted and returns zero.
        step(4'b0010, {4'd0, 4'd0, 4'd13, 4'd0}, '0, 1'b0, '0, '0, '0,
             4'b0010, '0, 1'b1, "oob");
        idle();
        check("oob err_bank_oob set", 256'(err_bank_oob), 256'(1));
        idle();
        idle();
        check("oob err_bank_oob sticky", 256'(err_bank_oob), 256'(1));
        check("oob stall_cnt", 256'(stall_cnt), 256'(3));

        // Reset right after an accept: the beat is discarded, RAM survives.
        step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, {10'd0, 10'd0, 10'd0, 10'd5}, 1'b0, '0, '0, '0,
             4'b0001, '0, 1'b0, "pre-reset read");
        @(posedge clk);
        #1;
        rst          = 1'b1;
        rd_req_valid = '0;
        #1;
        check("mid reset rd_valid", 256'(rd_valid), 256'(0));
        check("mid reset rd_data", rd_data[0], 256'(0));
        check("mid reset stall_cnt", 256'(stall_cnt), 256'(0));
        check("mid reset err_bank_oob", 256'(err_bank_oob), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(4'b1001, {4'd11, 4'd0, 4'd0, 4'd3}, {10'd5, 10'd0, 10'd0, 10'd5}, 1'b0, '0, '0, '0,
             4'b1001, {256'd11, 256'd0, 256'd0, 256'd3}, 1'b1, "post reset");
        step(4'b0001, {4'd0, 4'd0, 4'd0, 4'd1}, {10'd0, 10'd0, 10'd0, 10'd3}, 1'b0, '0, '0, '0,
             4'b0001, {256'd0, 256'd0, 256'd0, 256'hA5}, 1'b1, "post reset A5");
        idle();
        idle();
        check("post reset stall_cnt", 256'(stall_cnt), 256'(0));
        for (int p = 0; p < 4; p++) begin
            check($sformatf("port%0d queue drained", p), 256'(exp_q[p].size()), 256'(0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multi_bank_wbuf_rw.md
# multi_bank_wbuf_rw

Parametrised, writable multi-bank weight buffer for the Mamba SSM datapath (MAC mode): N_BANK single-port synchronous RAM banks serve N_PORT independent read ports through valid/ready handshakes, with per-cycle bank-conflict arbitration, same-address broadcast, one preload write port, and a saturating stall counter. It sits between the weight-preload DMA (write side) and the MAC-array controller (read side), replacing the fixed 4-port read-only buffer.

## Interface
- N_BANK, 12, number of banks (any value ≥ 2, not required to be a power of two)
- N_PORT, 4, number of read ports (1..8)
- ADDR_W, 10, per-bank word address width
- DATA_W, 256, word width
- BANK_W, $clog2(N_BANK), derived bank-index width
---
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_req_valid  in  N_PORT  per-port read request valid
- rd_req_ready  out  N_PORT  per-port request accepted this cycle
- rd_bank  in  N_PORT×BANK_W  target bank per port
- rd_addr  in  N_PORT×ADDR_W  word address per port
- rd_valid  out  N_PORT  read data valid (no backpressure)
- rd_data  out  N_PORT×DATA_W  read data, '0 when rd_valid low
- wr_valid  in  1  preload write request
- wr_ready  out  1  write accepted (always 1 when wr_bank in range)
- wr_bank  in  BANK_W  write target bank
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- err_bank_oob  out  1  sticky: any request with bank index ≥ N_BANK
- stall_cnt  out  32  saturating count of port-cycles with valid && !ready

## Operation
- Arbitration per bank, per cycle, combinational: write has highest priority; a bank granted to the write serves no read that cycle.
- Otherwise the lowest-indexed valid port targeting the bank wins; every other valid port targeting that bank with the **same** address is also granted (broadcast); ports with a different address get rd_req_ready = 0.
- Stalled ports must hold bank/addr stable until accepted; no fairness beyond fixed priority (controller schedules conflict-free in steady state).
- Out-of-range bank index (read or write): request accepted (ready = 1) so the requester cannot hang, no bank access, rd_valid still asserted one cycle later with rd_data = '0; err_bank_oob set until reset.
- Write-then-read same address: read accepted in any later cycle returns the new data. Write and read to the same bank in the same cycle: read stalls, then returns the new data.
- stall_cnt increments by the number of stalled ports each cycle, saturating at 32'hFFFF_FFFF.

## Timing
- Read latency 1: request accepted at edge T → rd_valid/rd_data valid in cycle after T; full throughput, one accepted request per port per cycle.
- Per-port rd_valid = registered accept; bank selection for the output mux uses the registered bank index of that port.
- Write commits at the accepting edge.
- rd_req_ready and wr_ready are combinational from current inputs (no registered state involved).
- Reset (any time, including mid-read): rd_valid = 0, rd_data = '0, err_bank_oob = 0, stall_cnt = 0; in-flight reads discarded; RAM contents not cleared. wr_ready/rd_req_ready during reset driven 0.

## Structure
- Package wbuf_pkg: BANK_W helper function, rd_req_t struct (bank, addr), default N_BANK/ADDR_W/DATA_W constants shared with the controller.
- Sub-module wbuf_bank: one synchronous single-port RAM (en, we, addr, din, dout, 1-cycle read); synthesis maps it to the RAM IP, simulation uses a behavioural array with hierarchical preload access.
- Top: arbiter (combinational grant matrix), accept/bank registers, output mux, counters.

## Test plan
- Preload banks 0..11 addr 5 with value = bank id via write port; read ports 0..3 request banks 0,3,7,11 addr 5 → all ready; next cycle rd_data = 0,3,7,11, stall_cnt = 0.
- Ports 0 and 2 both request bank 4, addr 9 vs 10 → port 0 ready, port 2 stalls one cycle (stall_cnt = 1), served next cycle with mem[4][10].
- Ports 0..3 all request bank 2 addr 7 → all ready same cycle (broadcast), all four rd_data = mem[2][7].
- Write bank 1 addr 3 = 0xA5 while port 0 reads bank 1 addr 3 → port 0 stalls, next cycle accepted, returns 0xA5.
- Port 1 requests bank 13 (N_BANK = 12) → ready, rd_valid next cycle with data '0, err_bank_oob = 1 and stays 1.
- Assert rst in the cycle after a read is accepted → rd_valid stays 0, stall_cnt = 0; after release, mem contents from before reset are still read back.
